// File: rtl/obuf_read_sched.sv
// obuf_read_sched: frame-aligned read scheduler for the camera output FIFO.
// Gates FIFO reads to frame boundaries, bursts reads toward the datapath,
// counts words per frame, flushes the pipeline on each SOF and flags
// short/long frames.
// Optional statistics (frame and drop counters) are built when the macro
// OBUF_SCHED_STATS_EN is defined; otherwise o_frame_cnt/o_drop_cnt read 0.
//
// state    | meaning
// IDLE     | disabled, no reads
// WAIT_SOF | between frames, stale words discarded
// FLUSH    | pipeline flush after accepted SOF
// RUN      | frame words read in bursts
module obuf_read_sched #(
    parameter int FRAME_PIXELS = 230400,
    parameter int BURST_LEN    = 16,
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 18
) (
    input  logic             i_sysclk,
    input  logic             db_rstn,
    input  logic             i_enable,
    input  logic             i_sof,
    input  logic             i_empty,
    input  logic             i_almostempty,
    input  logic             i_dst_ready,
    output logic             o_rd,
    output logic             o_valid,
    output logic             o_flush,
    output logic             o_frame_start,
    output logic             o_frame_done,
    output logic             o_err_short,
    output logic             o_err_long,
    output logic [CNT_W-1:0] o_pix_cnt,
    output logic [15:0]      o_frame_cnt,
    output logic [15:0]      o_drop_cnt
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FRAME_MAX  = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [BW-1:0]    BURST_FULL = BW'(BURST_LEN);
    localparam logic [FW-1:0]    FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, FLUSH, RUN} state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_base;
    logic [FW-1:0] flush_cnt;
    logic          long_pend;
    logic          burst_active;
    logic          frame_open;
    logic          last_rd;
    logic          discard;

    assign burst_active = (burst_cnt != '0);
    assign frame_open   = (o_pix_cnt < FRAME_MAX);
    assign last_rd      = o_rd && (state == RUN) && (o_pix_cnt == FRAME_LAST);
    assign discard      = o_rd && (state == WAIT_SOF);
    // A burst already in flight keeps counting; otherwise a new one arms when the FIFO fills.
    assign burst_base   = burst_active ? burst_cnt : (!i_almostempty ? BURST_FULL : '0);

    // Read strobe: discards between frames, burst-gated frame reads in RUN.
    always_comb begin
        o_rd = 1'b0;
        if (i_enable) begin
            case (state)
                WAIT_SOF: o_rd = !i_empty;
                RUN:      o_rd = !i_empty && i_dst_ready && (burst_active || !i_almostempty) && frame_open;
                default:  o_rd = 1'b0;
            endcase
        end
    end

    // Sequencer with registered pulse/status outputs.
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            state         <= IDLE;
            burst_cnt     <= '0;
            flush_cnt     <= '0;
            long_pend     <= 1'b0;
            o_valid       <= 1'b0;
            o_flush       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_err_short   <= 1'b0;
            o_err_long    <= 1'b0;
            o_pix_cnt     <= '0;
        end else begin
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_err_short   <= 1'b0;
            o_err_long    <= 1'b0;
            if (!i_enable) begin
                state     <= IDLE;
                o_flush   <= 1'b0;
                burst_cnt <= '0;
                long_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_SOF;
                    WAIT_SOF: begin
                        if (o_rd && long_pend) begin
                            o_err_long <= 1'b1;
                            long_pend  <= 1'b0;
                        end
                        if (i_sof) begin
                            state     <= FLUSH;
                            o_flush   <= 1'b1;
                            flush_cnt <= FLUSH_LOAD;
                            o_pix_cnt <= '0;
                            long_pend <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        if (i_sof) begin
                            flush_cnt <= FLUSH_LOAD;
                        end else if (flush_cnt == '0) begin
                            state         <= RUN;
                            o_flush       <= 1'b0;
                            o_frame_start <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt - 1'b1;
                        end
                    end
                    RUN: begin
                        o_valid   <= o_rd;
                        burst_cnt <= burst_base - BW'(o_rd);
                        if (o_rd) begin
                            o_pix_cnt <= o_pix_cnt + 1'b1;
                        end
                        if (last_rd) begin
                            o_frame_done <= 1'b1;
                            long_pend    <= 1'b1;
                            state        <= WAIT_SOF;
                            burst_cnt    <= '0;
                        end
                        // SOF wins over the WAIT_SOF transition; a completed frame is not short.
                        if (i_sof) begin
                            if (!last_rd) begin
                                o_err_short <= 1'b1;
                            end
                            state     <= FLUSH;
                            o_flush   <= 1'b1;
                            flush_cnt <= FLUSH_LOAD;
                            o_pix_cnt <= '0;
                            burst_cnt <= '0;
                            long_pend <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef OBUF_SCHED_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    // Completed-frame count (wraps) and saturating discard count.
    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (last_rd) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (discard && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign o_frame_cnt = frame_cnt;
    assign o_drop_cnt  = drop_cnt;
`else
    logic unused_stats;
    assign unused_stats = discard;
    assign o_frame_cnt  = 16'd0;
    assign o_drop_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_obuf_read_sched.sv
// Directed bench for obuf_read_sched with a 64-word frame, 16-word bursts
// and a 4-cycle flush. Inputs change on the falling edge; outputs are sampled
// 1 ns later, so o_rd reflects this cycle's inputs and the registered outputs
// reflect the previous rising edge.
module tb_obuf_read_sched;

    localparam int FP = 64;

`ifdef OBUF_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        i_sysclk;
    logic        db_rstn;
    logic        i_enable;
    logic        i_sof;
    logic        i_empty;
    logic        i_almostempty;
    logic        i_dst_ready;
    logic        o_rd;
    logic        o_valid;
    logic        o_flush;
    logic        o_frame_start;
    logic        o_frame_done;
    logic        o_err_short;
    logic        o_err_long;
    logic [17:0] o_pix_cnt;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_drop_cnt;

    obuf_read_sched #(
        .FRAME_PIXELS(FP),
        .BURST_LEN(16),
        .FLUSH_CYCLES(4),
        .CNT_W(18)
    ) dut (
        .i_sysclk(i_sysclk),
        .db_rstn(db_rstn),
        .i_enable(i_enable),
        .i_sof(i_sof),
        .i_empty(i_empty),
        .i_almostempty(i_almostempty),
        .i_dst_ready(i_dst_ready),
        .o_rd(o_rd),
        .o_valid(o_valid),
        .o_flush(o_flush),
        .o_frame_start(o_frame_start),
        .o_frame_done(o_frame_done),
        .o_err_short(o_err_short),
        .o_err_long(o_err_long),
        .o_pix_cnt(o_pix_cnt),
        .o_frame_cnt(o_frame_cnt),
        .o_drop_cnt(o_drop_cnt)
    );

    initial i_sysclk = 1'b0;
    always #5 i_sysclk = ~i_sysclk;

    // {rd, valid, flush, frame_start, frame_done, err_short, err_long}
    typedef struct {
        logic       rstn;
        logic       en;
        logic       sof;
        logic       emp;
        logic       ae;
        logic       rdy;
        logic [6:0] exp;
        int         pix;
    } vec_t;

    vec_t tbl[20];
    int   n_vec;
    int   n_err;
    int   vcount;

    function automatic logic [6:0] outs();
        return {o_rd, o_valid, o_flush, o_frame_start, o_frame_done, o_err_short, o_err_long};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rstn, input logic en, input logic sof,
                        input logic emp, input logic ae, input logic rdy);
        @(negedge i_sysclk);
        db_rstn       = rstn;
        i_enable      = en;
        i_sof         = sof;
        i_empty       = emp;
        i_almostempty = ae;
        i_dst_ready   = rdy;
        #1;
        if (o_valid) vcount++;
    endtask

    task automatic run_reads(input int n);
        for (int k = 0; k < n; k++) begin
            step(1, 1, 0, 0, 0, 1);
            chk("run_rd", int'(o_rd), 1);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vcount = 0;
        db_rstn = 1'b0;
        i_enable = 1'b1;
        i_sof = 1'b0;
        i_empty = 1'b0;
        i_almostempty = 1'b0;
        i_dst_ready = 1'b1;

        //          rstn  en    sof   emp   ae    rdy   expected      pix
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1000000, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0001000, 0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1100000, 1};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0100000, 2};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000, 2};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1000000, 2};

        // Reset, discard before SOF, flush with SOF reload, first burst reads.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rstn, tbl[i].en, tbl[i].sof, tbl[i].emp, tbl[i].ae, tbl[i].rdy);
            chk($sformatf("tbl%0d_out", i), int'(outs()), int'(tbl[i].exp));
            chk($sformatf("tbl%0d_pix", i), int'(o_pix_cnt), tbl[i].pix);
        end
        chk("reset_stats_frame", int'(o_frame_cnt), 0);

        // Burst continues while almost-empty until 16 reads are done.
        for (int i = 0; i < 13; i++) begin
            step(1, 1, 0, 0, 1, 1);
            chk("burst_rd", int'(o_rd), 1);
        end
        step(1, 1, 0, 0, 1, 1);
        chk("burst_end_rd", int'(o_rd), 0);
        chk("burst_end_pix", int'(o_pix_cnt), 16);

        // Downstream ready toggling: reads only follow ready.
        for (int i = 0; i < 95; i++) begin
            step(1, 1, 0, 0, 0, ((i % 2) == 0) ? 1'b1 : 1'b0);
            chk("toggle_rd", int'(o_rd), ((i % 2) == 0) ? 1 : 0);
        end
        step(1, 1, 0, 1, 1, 1);
        chk("f1_done_out", int'(outs()), 7'b0100100);
        chk("f1_pix", int'(o_pix_cnt), FP);
        chk("f1_valid_count", vcount, FP);
        step(1, 1, 0, 1, 1, 1);
        chk("f1_after_out", int'(outs()), 7'b0000000);

        // Surplus words after a completed frame: five discards, one long error.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0, 1);
            chk("surplus_out", int'(outs()), (i == 1) ? 7'b1000001 : 7'b1000000);
        end
        step(1, 1, 0, 1, 1, 1);
        chk("surplus_end_out", int'(outs()), 7'b0000000);
        chk("drop_cnt", int'(o_drop_cnt), STATS ? 7 : 0);
        chk("frame_cnt1", int'(o_frame_cnt), STATS ? 1 : 0);

        // SOF after 40 words: short-frame error and a plain 4-cycle flush.
        step(1, 1, 1, 1, 1, 1);
        chk("sof_rd", int'(o_rd), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 1);
            chk("flush4_out", int'(outs()), 7'b0010000);
        end
        step(1, 1, 0, 1, 1, 1);
        chk("start_out", int'(outs()), 7'b0001000);
        run_reads(40);
        step(1, 1, 1, 1, 1, 1);
        chk("short_sof_out", int'(outs()), 7'b0100000);
        chk("short_sof_pix", int'(o_pix_cnt), 40);
        step(1, 1, 0, 1, 1, 1);
        chk("short_err_out", int'(outs()), 7'b0010010);
        chk("short_err_pix", int'(o_pix_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 1);
            chk("short_flush_out", int'(outs()), 7'b0010000);
        end
        step(1, 1, 0, 1, 1, 1);
        chk("restart_out", int'(outs()), 7'b0001000);

        // Continuous frame; SOF coincides with the 64th read.
        vcount = 0;
        run_reads(FP - 1);
        step(1, 1, 1, 0, 0, 1);
        chk("last_rd_sof", int'(o_rd), 1);
        step(1, 1, 0, 1, 1, 1);
        chk("sof_on_last_out", int'(outs()), 7'b0110100);
        chk("sof_on_last_pix", int'(o_pix_cnt), 0);
        chk("f3_valid_count", vcount, FP);
        chk("frame_cnt2", int'(o_frame_cnt), STATS ? 2 : 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 1);
        end
        step(1, 1, 0, 1, 1, 1);
        chk("f4_start_out", int'(outs()), 7'b0001000);

        // Enable dropped mid-burst, then re-enabled without a new SOF.
        step(1, 1, 0, 0, 0, 1);
        chk("f4_rd0", int'(o_rd), 1);
        step(1, 1, 0, 0, 1, 1);
        chk("f4_rd1", int'(o_rd), 1);
        step(1, 0, 0, 0, 1, 1);
        chk("disable_out", int'(outs()), 7'b0100000);
        step(1, 1, 0, 0, 0, 1);
        chk("idle_out", int'(outs()), 7'b0000000);
        step(1, 1, 0, 0, 0, 1);
        chk("reenable_discard_out", int'(outs()), 7'b1000000);
        step(1, 1, 0, 1, 1, 1);
        chk("reenable_after_out", int'(outs()), 7'b0000000);
        chk("drop_cnt_final", int'(o_drop_cnt), STATS ? 8 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
